// File: rtl/eecs4612_mem_pkg.sv
// Shared command/size codes, default widths, FSM states and lane helpers
// for the memory responder.
package eecs4612_mem_pkg;

  localparam int MEM_ADDR_W = 40;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_CMD_W  = 5;
  localparam int MEM_TYP_W  = 3;

  localparam logic [4:0] M_XRD = 5'd0;
  localparam logic [4:0] M_XWR = 5'd1;

  localparam logic [2:0] MT_B = 3'd0;
  localparam logic [2:0] MT_H = 3'd1;
  localparam logic [2:0] MT_W = 3'd2;
  localparam logic [2:0] MT_D = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_CMD_W-1:0]  cmd;
    logic [MEM_TYP_W-1:0]  typ;
    logic [MEM_DATA_W-1:0] data;
  } mem_req_t;

  // Bytes covered by an access of the given size, starting at lane 0.
  function automatic logic [7:0] typ_byte_mask(input logic [1:0] typ);
    case (typ)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Force the byte lane down to the natural alignment of the access size.
  function automatic logic [2:0] align_lane(input logic [1:0] typ, input logic [2:0] lane);
    case (typ)
      2'd0:    return lane;
      2'd1:    return {lane[2:1], 1'b0};
      2'd2:    return {lane[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous in-order request queue with full/empty flags.
// Pointers carry one wrap bit so full and empty are distinguishable.
module mem_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  // A full queue refuses the push even when the same cycle pops.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory model: queued requests are serviced one at a time,
// the backing word is read/modified/written on entry to RESP.
module mem_responder
  import eecs4612_mem_pkg::*;
#(
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 4,
  parameter int QDEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req_ready_o,
  input  logic              mem_req_valid_i,
  input  logic [ADDR_W-1:0] mem_req_addr_i,
  input  logic [4:0]        mem_req_cmd_i,
  input  logic [2:0]        mem_req_typ_i,
  input  logic [DATA_W-1:0] mem_req_data_i,
  output logic              mem_resp_valid_o,
  output logic [ADDR_W-1:0] mem_resp_addr_o,
  output logic [4:0]        mem_resp_cmd_o,
  output logic [2:0]        mem_resp_typ_o,
  output logic [DATA_W-1:0] mem_resp_data_o,
  output logic [1:0]        dbg_state_o
);

  localparam int         REQ_W    = ADDR_W + 5 + 3 + DATA_W;
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic [REQ_W-1:0]   r_cur;
  logic               r_resp_valid;
  logic [ADDR_W-1:0]  r_resp_addr;
  logic [4:0]         r_resp_cmd;
  logic [2:0]         r_resp_typ;
  logic [DATA_W-1:0]  r_resp_data;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic [REQ_W-1:0]   w_head;
  logic               w_full, w_empty, w_push, w_pop, w_fire, w_mem_we;
  logic [ADDR_W-1:0]  w_cur_addr;
  logic [4:0]         w_cur_cmd;
  logic [2:0]         w_cur_typ;
  logic [DATA_W-1:0]  w_cur_data;
  logic [IDX_W-1:0]   w_idx;
  logic [2:0]         w_lane;
  logic [5:0]         w_sh;
  logic [7:0]         w_tbytes, w_lbytes;
  logic [DATA_W-1:0]  w_tmask, w_wmask, w_old, w_new, w_load, w_echo, w_resp_data;

  assign mem_req_ready_o = !w_full;
  assign w_push          = mem_req_valid_i && !w_full;

  mem_req_fifo #(.WIDTH(REQ_W), .DEPTH(QDEPTH)) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_din   ({mem_req_addr_i, mem_req_cmd_i, mem_req_typ_i, mem_req_data_i}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_cur_addr, w_cur_cmd, w_cur_typ, w_cur_data} = r_cur;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
          w_fire      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = CNT_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Lane selection and read-modify-write of the addressed 64-bit word.
  always_comb begin
    w_idx    = w_cur_addr[3 +: IDX_W];
    w_lane   = align_lane(w_cur_typ[1:0], w_cur_addr[2:0]);
    w_sh     = {w_lane, 3'b000};
    w_tbytes = typ_byte_mask(w_cur_typ[1:0]);
    w_lbytes = w_tbytes << w_lane;
    w_tmask  = '0;
    w_wmask  = '0;
    for (int i = 0; i < 8; i++) begin
      w_tmask[i*8 +: 8] = {8{w_tbytes[i]}};
      w_wmask[i*8 +: 8] = {8{w_lbytes[i]}};
    end
    w_old  = r_mem[w_idx];
    w_load = (w_old >> w_sh) & w_tmask;
    w_echo = w_cur_data & w_tmask;
    w_new  = (w_old & ~w_wmask) | ((w_cur_data << w_sh) & w_wmask);
    w_resp_data = '0;
    if (w_cur_cmd == M_XRD)      w_resp_data = w_load;
    else if (w_cur_cmd == M_XWR) w_resp_data = w_echo;
  end

  assign w_mem_we = w_fire && (w_cur_cmd == M_XWR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cur        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_cmd   <= '0;
      r_resp_typ   <= '0;
      r_resp_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_resp_valid <= w_fire;
      if (w_pop) r_cur <= w_head;
      if (w_fire) begin
        r_resp_addr <= w_cur_addr;
        r_resp_cmd  <= w_cur_cmd;
        r_resp_typ  <= w_cur_typ;
        r_resp_data <= w_resp_data;
      end
    end
  end

  // Backing store keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_new;
  end

  assign mem_resp_valid_o = r_resp_valid;
  assign mem_resp_addr_o  = r_resp_addr;
  assign mem_resp_cmd_o   = r_resp_cmd;
  assign mem_resp_typ_o   = r_resp_typ;
  assign mem_resp_data_o  = r_resp_data;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: driver pushes expected responses
// (with their due cycle) into a queue, a negedge monitor pops and compares.
module tb_mem_responder;
  import eecs4612_mem_pkg::*;

  localparam int L  = 4;
  localparam int EW = 32 + 40 + 5 + 3 + 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_ready_o;
  logic        mem_req_valid_i;
  logic [39:0] mem_req_addr_i;
  logic [4:0]  mem_req_cmd_i;
  logic [2:0]  mem_req_typ_i;
  logic [63:0] mem_req_data_i;
  logic        mem_resp_valid_o;
  logic [39:0] mem_resp_addr_o;
  logic [4:0]  mem_resp_cmd_o;
  logic [2:0]  mem_resp_typ_o;
  logic [63:0] mem_resp_data_o;
  logic [1:0]  dbg_state_o;

  logic [EW-1:0]  exp_q[$];
  logic [111:0]   last_f;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_edge = -1000;
  int burst_cnt = 0;
  int low_at = -1;

  mem_responder dut (
    .clk              (clk),
    .reset            (reset),
    .mem_req_ready_o  (mem_req_ready_o),
    .mem_req_valid_i  (mem_req_valid_i),
    .mem_req_addr_i   (mem_req_addr_i),
    .mem_req_cmd_i    (mem_req_cmd_i),
    .mem_req_typ_i    (mem_req_typ_i),
    .mem_req_data_i   (mem_req_data_i),
    .mem_resp_valid_o (mem_resp_valid_o),
    .mem_resp_addr_o  (mem_resp_addr_o),
    .mem_resp_cmd_o   (mem_resp_cmd_o),
    .mem_resp_typ_o   (mem_resp_typ_o),
    .mem_resp_data_o  (mem_resp_data_o),
    .dbg_state_o      (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; holds valid until the request is accepted.
  task automatic send(input logic [39:0] a, input logic [4:0] c, input logic [2:0] t,
                      input logic [63:0] d, input logic [63:0] exp_d);
    int tries = 0;
    bit done = 0;
    int acc, e;
    mem_req_valid_i = 1'b1;
    mem_req_addr_i  = a;
    mem_req_cmd_i   = c;
    mem_req_typ_i   = t;
    mem_req_data_i  = d;
    while (!done) begin
      if (mem_req_ready_o) begin
        acc = cyc + 1;
        e = ((acc > prev_edge) ? acc : prev_edge) + L + 1;
        prev_edge = e;
        exp_q.push_back({e[31:0], a, c, t, exp_d});
        burst_cnt++;
        done = 1;
      end else begin
        if (low_at < 0) low_at = burst_cnt;
        tries++;
        if (tries > 100) begin
          chk("accept_timeout", 64'(tries), 64'd0);
          done = 1;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic idle();
    mem_req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle();
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] ent;
    if (!reset) begin
      chk("rst_valid_ready", {62'd0, mem_resp_valid_o, mem_req_ready_o}, 64'd1);
      chk("rst_fields", {16'd0, mem_resp_addr_o, mem_resp_cmd_o, mem_resp_typ_o}, 64'd0);
      chk("rst_data", mem_resp_data_o, 64'd0);
      chk("rst_state", {62'd0, dbg_state_o}, {62'd0, ST_IDLE});
      last_f = '0;
    end else if (mem_resp_valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'(exp_q.size()), 64'd1);
      end else begin
        ent = exp_q.pop_front();
        chk("resp_cycle", 64'(cyc), {32'd0, ent[EW-1 -: 32]});
        chk("resp_addr", {24'd0, mem_resp_addr_o}, {24'd0, ent[111:72]});
        chk("resp_cmd_typ", {56'd0, mem_resp_cmd_o, mem_resp_typ_o}, {56'd0, ent[71:64]});
        chk("resp_data", mem_resp_data_o, ent[63:0]);
      end
      last_f = {mem_resp_addr_o, mem_resp_cmd_o, mem_resp_typ_o, mem_resp_data_o};
    end else begin
      chk("hold_data", mem_resp_data_o, last_f[63:0]);
      chk("hold_fields", {16'd0, mem_resp_addr_o, mem_resp_cmd_o, mem_resp_typ_o},
          {16'd0, last_f[111:64]});
      if (exp_q.size() != 0) begin
        ent = exp_q[0];
        if (int'(ent[EW-1 -: 32]) < cyc) begin
          chk("late_resp", 64'(cyc), {32'd0, ent[EW-1 -: 32]});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    mem_req_valid_i = 1'b0;
    mem_req_addr_i  = '0;
    mem_req_cmd_i   = '0;
    mem_req_typ_i   = '0;
    mem_req_data_i  = '0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);

    // store dword then load it back; first response due accept+5
    send(40'h40, M_XWR, MT_D, 64'h1122334455667788, 64'h1122334455667788);
    send(40'h40, M_XRD, MT_D, 64'h0, 64'h1122334455667788);
    drain();

    // byte store over a zeroed word, then lane-selected loads
    send(40'h40, M_XWR, MT_D, 64'h0, 64'h0);
    send(40'h43, M_XWR, MT_B, 64'hFFFF_12AB, 64'hAB);
    send(40'h40, M_XRD, MT_D, 64'h0, 64'h00000000AB000000);
    send(40'h42, M_XRD, MT_H, 64'h0, 64'hAB00);
    send(40'h43, M_XRD, MT_H, 64'h0, 64'hAB00);
    send(40'h43, M_XRD, MT_B, 64'h0, 64'hAB);
    send(40'h41, M_XRD, MT_W, 64'h0, 64'hAB000000);
    send(40'h44, M_XRD, MT_W, 64'h0, 64'h0);
    drain();

    // six back-to-back loads with valid held high
    burst_cnt = 0;
    low_at = -1;
    send(40'h40, M_XRD, MT_B, 64'h0, 64'h00);
    send(40'h41, M_XRD, MT_B, 64'h0, 64'h00);
    send(40'h42, M_XRD, MT_B, 64'h0, 64'h00);
    send(40'h43, M_XRD, MT_B, 64'h0, 64'hAB);
    send(40'h44, M_XRD, MT_B, 64'h0, 64'h00);
    send(40'h45, M_XRD, MT_B, 64'h0, 64'h00);
    chk("ready_low_after_accepts", 64'(low_at), 64'd5);
    drain();

    // address wrap above DEPTH*8 bytes
    send(40'h40, M_XWR, MT_B, 64'h5A, 64'h5A);
    send(40'h8040, M_XRD, MT_B, 64'h0, 64'h5A);
    send(40'hFF_0000_8040, M_XRD, MT_D, 64'h0, 64'h00000000AB00005A);
    drain();

    // unknown command: data 0, memory untouched
    send(40'h40, 5'd7, MT_D, 64'hDEAD_BEEF_0000_0000, 64'h0);
    send(40'h40, M_XRD, MT_D, 64'h0, 64'h00000000AB00005A);
    drain();

    // reset while BUSY with three requests queued
    send(40'h40, M_XRD, MT_D, 64'h0, 64'h0);
    send(40'h48, M_XRD, MT_D, 64'h0, 64'h0);
    send(40'h50, M_XRD, MT_D, 64'h0, 64'h0);
    send(40'h58, M_XRD, MT_D, 64'h0, 64'h0);
    idle();
    chk("busy_before_reset", {62'd0, dbg_state_o}, {62'd0, ST_BUSY});
    @(posedge clk); #2;
    reset = 1'b0;
    exp_q.delete();
    prev_edge = -1000;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, mem_req_ready_o}, 64'd1);
    @(posedge clk); #2 reset = 1'b1;
    repeat (20) @(negedge clk);
    send(40'h40, M_XRD, MT_D, 64'h0, 64'h00000000AB00005A);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 SHALL have parameters (name, default, meaning): ADDR_W, 40, request address width.
REQ-003 SHALL have parameters: DATA_W, 64, data width; DEPTH, 4096, number of 64-bit backing words (power of 2).
REQ-004 SHALL have parameters: LATENCY, 4, service cycles per request (1..15); QDEPTH, 4, request queue entries (power of 2).
REQ-005 SHALL have ports: clk  in  1  clock.
REQ-006 SHALL have ports: reset  in  1  async active-low reset.
REQ-007 SHALL have ports: mem_req_ready_o  out  1  queue not full.
REQ-008 SHALL have ports: mem_req_valid_i  in  1  request present.
REQ-009 SHALL have ports: mem_req_addr_i  in  ADDR_W  byte address.
REQ-010 SHALL have ports: mem_req_cmd_i  in  5  0=load, 1=store.
REQ-011 SHALL have ports: mem_req_typ_i  in  3  0=byte, 1=half, 2=word, 3=dword.
REQ-012 SHALL have ports: mem_req_data_i  in  DATA_W  store data, LSB-aligned.
REQ-013 SHALL have ports: mem_resp_valid_o  out  1  one-cycle response strobe; there is no ready.
REQ-014 SHALL have ports: mem_resp_addr_o, mem_resp_cmd_o, mem_resp_typ_o, mem_resp_data_o  out  ADDR_W/5/3/DATA_W  echoed fields and result.

Function
REQ-015 A request SHALL be accepted on a rising edge where mem_req_valid_i && mem_req_ready_o; it is enqueued in order.
REQ-016 mem_req_ready_o SHALL be low iff the queue holds QDEPTH entries; it SHALL NOT depend combinationally on mem_req_valid_i.
REQ-017 Pop and push in the same cycle SHALL be legal when not full; when full, no request is accepted even if a pop occurs.
REQ-018 The FSM SHALL have states IDLE, BUSY, RESP. IDLE->BUSY pops the head when the queue is non-empty and loads the counter with LATENCY-1.
REQ-019 BUSY SHALL decrement the counter and move to RESP at 0. RESP SHALL drive the response for one cycle, then go to BUSY if the queue is non-empty (pop), otherwise to IDLE.
REQ-020 A request accepted on edge E0 into an empty, idle block SHALL have mem_resp_valid_o high only in the cycle after edge E0+LATENCY+1.
REQ-021 Queued requests SHALL produce responses spaced exactly LATENCY+1 cycles apart, in acceptance order.
REQ-022 Word index SHALL be addr[3 +: log2(DEPTH)]; higher address bits SHALL wrap silently. Byte lane SHALL be addr[2:0], with lane bits forced to the natural alignment of typ; dword ignores addr[2:0].
REQ-023 A load SHALL return the selected lane zero-extended to DATA_W in mem_resp_data_o.
REQ-024 A store SHALL write only the lane bytes. mem_resp_data_o SHALL echo the store data masked to typ width.
REQ-025 Memory SHALL be read and written on entry to RESP, so a store followed by a load to the same address returns the new data.
REQ-026 cmd not equal to 0 or 1 SHALL still respond, with data 0 and memory unchanged.
REQ-027 Response fields SHALL be registered and SHALL hold their last values when mem_resp_valid_o is low.

Reset
REQ-028 While reset is low: mem_resp_valid_o=0, all response fields=0, queue empty, mem_req_ready_o=1, FSM=IDLE, counter=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued and in-flight requests with no response issued. Backing memory contents SHALL NOT be reset.

Structure
REQ-030 Package eecs4612_mem_pkg SHALL hold the cmd codes (M_XRD=0, M_XWR=1), typ codes (MT_B..MT_D), ADDR_W/DATA_W constants and the request struct typedef.
REQ-031 The request queue SHALL be one sub-module, mem_req_fifo: synchronous, parameterised by width and depth, with full/empty outputs. The FSM, lane logic and memory array stay in mem_responder.

Verification
REQ-032 Bench SHALL cover: store dword 0x1122334455667788 @0x40, then load dword @0x40 -> second response data 0x1122334455667788, first response at accept+LATENCY+1 (5 cycles).
REQ-033 Bench SHALL cover: store byte 0xAB @0x43 over a zeroed word, then load dword @0x40 -> 0x00000000AB000000; load half @0x42 -> 0xAB00.
REQ-034 Bench SHALL cover: hold valid for 6 back-to-back loads -> ready low after 5 accepts (4 queued plus 1 popped), responses 5 cycles apart, in order, addr echoed.
REQ-035 Bench SHALL cover: store 0x5A @0x40, then load @0x40+DEPTH*8 -> wraps, returns 0x5A.
REQ-036 Bench SHALL cover: cmd=7 -> response with data 0 and memory unchanged; assert reset during BUSY with 3 queued -> no response, ready=1 next cycle, earlier stored data still readable.
